reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Round-robin arbiter and transfer sequencer for the shared 18-bit register bus, i.e. the R13..R19/R bank behind the register C controller.
- Grants up to N_REQ requesters (e.g. fetch, ALU, memory I/F, control unit) exclusive, single-register read or write transactions.
- Drives reg_addr/swap1 to the register controller, strobes the register write, and returns read data with a done pulse.

Parameters:
- DW, 18, register/bus data width.
- AW, 3, register address width (8 registers; address 0 = R, 1..7 = R13..R19).
- N_REQ, 4, number of requesters (ports below are flattened per requester, requester i at slice i).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester transaction request, level; held until done.
- wr  in  N_REQ  per-requester op: 1 = write, 0 = read.
- addr_in  in  N_REQ*AW  per-requester register address.
- wdata_in  in  N_REQ*DW  per-requester write data.
- bus_in  in  DW  shared bus as driven by the register controller.
- gnt  out  N_REQ  one-hot grant, 0 when idle.
- done  out  N_REQ  one-cycle one-hot completion pulse.
- rdata  out  DW  read result, valid from the done cycle until the next read completes.
- reg_addr  out  AW  register select to the register controller.
- swap1  out  1  1 = selected register drives bus (read), 0 = bus forced 0.
- reg_we  out  1  one-cycle write strobe qualifying the controller's one-hot enable.
- reg_wdata  out  DW  data written on reg_we.

Behaviour:
- Reset values:
  - gnt=0, done=0, rdata=0, reg_addr=0, swap1=0, reg_we=0, reg_wdata=0.
  - State=IDLE, priority pointer ptr=0 (requester 0 highest).
- FSM states are IDLE, SETUP, XFER, DONE. Every transaction takes exactly 4 cycles, IDLE to IDLE.
- IDLE:
  - If req!=0, select the first asserted requester scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
  - Latch its wr, addr, wdata; go to SETUP.
  - Otherwise stay in IDLE.
- SETUP:
  - gnt[i]=1, reg_addr=latched addr.
  - swap1=~wr. Bus settles this cycle.
- XFER:
  - Outputs are held from SETUP.
  - Read: rdata<=bus_in at the end of the cycle.
  - Write: reg_we=1 and reg_wdata=latched wdata, this cycle only.
- DONE:
  - done[i]=1 for one cycle; gnt[i] still 1.
  - swap1=0, reg_we=0.
  - ptr<=(i+1) mod N_REQ. Next state is IDLE.
- Entering IDLE: gnt=0, reg_addr holds its last value.
- Request rules:
  - req[i] sampled only in IDLE.
  - req/wr/addr/wdata changes after latching are ignored.
  - Dropping req mid-transaction does not abort: the transaction completes and done still pulses.
  - A requester holding req after done is re-arbitrated normally in the next IDLE; it gets lowest priority due to the ptr update.
- Simultaneous requests: strictly one grant. Losers wait; no starvation, since worst-case wait is (N_REQ-1) transactions.
- Only the address/data of the granted requester are ever used.
- Invariants: gnt and done are always zero- or one-hot. reg_we is never asserted outside XFER. swap1 and reg_we are never both 1.
- rst in any state returns to reset values next edge. An in-flight write whose XFER edge coincides with rst does not strobe reg_we.
- rdata is not cleared by writes.

Test Plan:
- Read: reset, reg bank addr 3 = 18'h2A5A5; req[1]=1, wr[1]=0, addr=3 -> gnt=4'b0010 at T+1, swap1=1/reg_addr=3 at T+1..T+2, done=4'b0010 at T+3 with rdata=18'h2A5A5, gnt=0 at T+4.
- Write: req[2], wr=1, addr=0, wdata=18'h3FFFF -> reg_we=1 with reg_wdata=18'h3FFFF, reg_addr=0, swap1=0 exactly at T+2; done[2] at T+3.
- Contention: req=4'b1111 held continuously from reset -> grants in order 0,1,2,3,0, each 4 cycles apart, one done per grant.
- Wrap/fairness: ptr=3 after granting requester 2; req=4'b0101 -> requester 0 granted (scan wraps 3->0).
- Drop req: req[0] deasserted in SETUP -> transaction completes, done[0] at T+3, no re-grant.
- Reset mid-write: rst=1 during SETUP of a write -> reg_we never pulses, all outputs 0 next cycle, ptr=0.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter and four-phase transfer sequencer for the shared register bus.
// One single-register read or write per grant: IDLE -> SETUP -> XFER -> DONE -> IDLE.
module reg_bus_arbiter #(
  parameter int DW    = 18,
  parameter int AW    = 3,
  parameter int N_REQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    wr,
  input  logic [N_REQ*AW-1:0] addr_in,
  input  logic [N_REQ*DW-1:0] wdata_in,
  input  logic [DW-1:0]       bus_in,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       reg_addr,
  output logic                swap1,
  output logic                reg_we,
  output logic [DW-1:0]       reg_wdata
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SUMW = PW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   sel_reg;
  logic            wr_reg;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   wdata_reg;
  logic [DW-1:0]   rdata_reg;

  logic [PW-1:0]      pick;
  logic               found;
  logic               take;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [SUMW-1:0]    sum;
  logic [SUMW-1:0]    ptr_sum;
  logic [PW-1:0]      ptr_next;

  // Rotate requests so bit 0 is the current highest-priority requester,
  // then map the first set offset back to an absolute index modulo N_REQ.
  always_comb begin
    req_dbl = {req, req} >> ptr_reg;
    req_rot = req_dbl[N_REQ-1:0];
    pick    = '0;
    found   = 1'b0;
    sum     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_reg} + SUMW'(k);
        if (sum >= SUMW'(N_REQ)) begin
          sum = sum - SUMW'(N_REQ);
        end
        pick = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    ptr_sum = {1'b0, sel_reg} + SUMW'(1);
    if (ptr_sum >= SUMW'(N_REQ)) begin
      ptr_sum = '0;
    end
    ptr_next = ptr_sum[PW-1:0];
  end

  assign take = (state_reg == IDLE) && found;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (found) state_next = SETUP;
      SETUP:   state_next = XFER;
      XFER:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      sel_reg   <= '0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        sel_reg   <= pick;
        wr_reg    <= wr[pick];
        addr_reg  <= addr_in[pick*AW +: AW];
        wdata_reg <= wdata_in[pick*DW +: DW];
      end
      if (state_reg == XFER && !wr_reg) begin
        rdata_reg <= bus_in;
      end
      if (state_reg == DONE) begin
        ptr_reg <= ptr_next;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign gnt[gi]  = (state_reg != IDLE) && (sel_reg == PW'(gi));
      assign done[gi] = (state_reg == DONE) && (sel_reg == PW'(gi));
    end
  endgenerate

  // reg_addr keeps the last latched address while idle; the strobe is
  // suppressed on a reset cycle so an interrupted write never lands.
  assign reg_addr  = addr_reg;
  assign swap1     = ((state_reg == SETUP) || (state_reg == XFER)) && !wr_reg;
  assign reg_we    = (state_reg == XFER) && wr_reg && !rst;
  assign reg_wdata = reg_we ? wdata_reg : '0;
  assign rdata     = rdata_reg;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: a behavioural register bank drives bus_in,
// expected completions are queued at stimulus time and checked at each done.
module tb_reg_bus_arbiter;

  localparam int DW = 18;
  localparam int AW = 3;
  localparam int N  = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    wr;
  logic [N*AW-1:0] addr_in;
  logic [N*DW-1:0] wdata_in;
  logic [DW-1:0]   bus_in;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   reg_addr;
  logic            swap1;
  logic            reg_we;
  logic [DW-1:0]   reg_wdata;

  typedef struct {
    logic [N-1:0]  done;
    logic          chk;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp;
  int   n_err;

  logic [DW-1:0] bank [0:7];
  logic          bank_load;

  reg_bus_arbiter #(.DW(DW), .AW(AW), .N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr_in(addr_in),
    .wdata_in(wdata_in), .bus_in(bus_in), .gnt(gnt), .done(done),
    .rdata(rdata), .reg_addr(reg_addr), .swap1(swap1), .reg_we(reg_we),
    .reg_wdata(reg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int k);
    logic [2:0] kk;
    kk = k[2:0];
    if (k == 3) return 18'h2A5A5;
    return {kk, 15'h0ABC};
  endfunction

  // Register bank model: drives the bus when selected, captures write strobes.
  always @(posedge clk) begin
    if (bank_load) begin
      for (int k = 0; k < 8; k++) bank[k] <= init_val(k);
    end else if (reg_we) begin
      bank[reg_addr] <= reg_wdata;
    end
  end
  assign bus_in = swap1 ? bank[reg_addr] : '0;

  task automatic clear_inputs;
    req = '0; wr = '0; addr_in = '0; wdata_in = '0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i] = 1'b1;
    wr[i]  = w;
    addr_in[i*AW +: AW]  = a;
    wdata_in[i*DW +: DW] = d;
  endtask

  task automatic push_exp(input logic [N-1:0] d, input logic c, input logic [DW-1:0] r);
    exp_t x;
    x.done = d; x.chk = c; x.rdata = r;
    exp_q.push_back(x);
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    bank_load = 1'b1;
    repeat (2) @(negedge clk);
    bank_load = 1'b0;
    n_cmp++;
    if ({gnt, done, rdata, reg_addr, swap1, reg_we, reg_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt=%b done=%b rdata=%h addr=%0d swap1=%b we=%b wdata=%h, want all 0",
               gnt, done, rdata, reg_addr, swap1, reg_we, reg_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (gnt !== '0 || done !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got gnt=%b done=%b, want 0/0", gnt, done);
    end
  endtask

  task automatic test_read;
    clear_inputs();
    set_req(1, 1'b0, 3'd3, '0);
    push_exp(4'b0010, 1'b1, 18'h2A5A5);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2) begin
        n_cmp++;
        if (gnt !== 4'b0010 || swap1 !== 1'b1 || reg_addr !== 3'd3 || reg_we !== 1'b0) begin
          n_err++;
          $display("FAIL read_t%0d: got gnt=%b swap1=%b addr=%0d we=%b, want 0010/1/3/0",
                   c, gnt, swap1, reg_addr, reg_we);
        end
      end
      if (c == 3) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL read_sb: got done=%b, want queued entry", done);
        end else begin
          e = exp_q.pop_front();
          n_cmp += 2;
          if (done !== e.done) begin
            n_err++; $display("FAIL read_done: got %b, want %b", done, e.done);
          end
          if (rdata !== e.rdata) begin
            n_err++; $display("FAIL read_rdata: got %h, want %h", rdata, e.rdata);
          end
          $display("txn read  req=1 done=%b rdata=%h", done, rdata);
        end
        req = '0;
      end
      if (c == 4) begin
        n_cmp++;
        if (gnt !== '0 || done !== '0 || rdata !== 18'h2A5A5 || reg_addr !== 3'd3) begin
          n_err++;
          $display("FAIL read_idle: got gnt=%b done=%b rdata=%h addr=%0d, want 0/0/2a5a5/3",
                   gnt, done, rdata, reg_addr);
        end
      end
    end
  endtask

  task automatic test_write;
    clear_inputs();
    set_req(2, 1'b1, 3'd0, 18'h3FFFF);
    push_exp(4'b0100, 1'b0, '0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if (gnt !== 4'b0100 || reg_we !== 1'b0 || swap1 !== 1'b0) begin
          n_err++;
          $display("FAIL write_setup: got gnt=%b we=%b swap1=%b, want 0100/0/0", gnt, reg_we, swap1);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (reg_we !== 1'b1 || reg_wdata !== 18'h3FFFF || reg_addr !== 3'd0 || swap1 !== 1'b0) begin
          n_err++;
          $display("FAIL write_xfer: got we=%b wdata=%h addr=%0d swap1=%b, want 1/3ffff/0/0",
                   reg_we, reg_wdata, reg_addr, swap1);
        end
      end
      if (c == 3) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL write_sb: got done=%b, want queued entry", done);
        end else begin
          e = exp_q.pop_front();
          n_cmp += 2;
          if (done !== e.done) begin
            n_err++; $display("FAIL write_done: got %b, want %b", done, e.done);
          end
          if (reg_we !== 1'b0) begin
            n_err++; $display("FAIL write_we_done: got %b, want 0", reg_we);
          end
          $display("txn write req=2 done=%b bank0=%h", done, bank[0]);
        end
        req = '0;
      end
      if (c == 4) begin
        n_cmp++;
        if (rdata !== 18'h2A5A5 || bank[0] !== 18'h3FFFF) begin
          n_err++;
          $display("FAIL write_after: got rdata=%h bank0=%h, want 2a5a5/3ffff", rdata, bank[0]);
        end
      end
    end
  endtask

  task automatic test_wrap;
    clear_inputs();
    set_req(0, 1'b0, 3'd0, '0);
    set_req(2, 1'b0, 3'd3, '0);
    push_exp(4'b0001, 1'b1, 18'h3FFFF);
    push_exp(4'b0100, 1'b1, 18'h2A5A5);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1 || c == 5) begin
        n_cmp++;
        if (gnt !== ((c == 1) ? 4'b0001 : 4'b0100)) begin
          n_err++;
          $display("FAIL wrap_gnt_t%0d: got %b, want %b", c, gnt, (c == 1) ? 4'b0001 : 4'b0100);
        end
      end
      if (c == 3 || c == 7) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wrap_sb: got done=%b, want queued entry", done);
        end else begin
          e = exp_q.pop_front();
          n_cmp += 2;
          if (done !== e.done) begin
            n_err++; $display("FAIL wrap_done: got %b, want %b", done, e.done);
          end
          if (rdata !== e.rdata) begin
            n_err++; $display("FAIL wrap_rdata: got %h, want %h", rdata, e.rdata);
          end
          $display("txn read  wrap done=%b rdata=%h", done, rdata);
        end
        if (c == 7) req = '0;
      end
      if (c == 4 || c == 8) begin
        n_cmp++;
        if (gnt !== '0) begin
          n_err++; $display("FAIL wrap_idle_t%0d: got gnt=%b, want 0", c, gnt);
        end
      end
    end
  endtask

  task automatic test_contention;
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i + 1), '0);
    for (int k = 0; k < 5; k++) push_exp(N'(1 << (k % N)), 1'b1, init_val(k % N + 1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (!$onehot0(gnt) || !$onehot0(done) || (swap1 && reg_we)) begin
        n_err++;
        $display("FAIL cont_invariant_t%0d: got gnt=%b done=%b swap1=%b we=%b", c, gnt, done, swap1, reg_we);
      end
      if (c % 4 == 1) begin
        n_cmp++;
        if (gnt !== N'(1 << ((c / 4) % N))) begin
          n_err++;
          $display("FAIL cont_gnt_t%0d: got %b, want %b", c, gnt, N'(1 << ((c / 4) % N)));
        end
      end
      if (c % 4 == 3) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL cont_sb: got done=%b, want queued entry", done);
        end else begin
          e = exp_q.pop_front();
          n_cmp += 2;
          if (done !== e.done) begin
            n_err++; $display("FAIL cont_done: got %b, want %b", done, e.done);
          end
          if (rdata !== e.rdata) begin
            n_err++; $display("FAIL cont_rdata: got %h, want %h", rdata, e.rdata);
          end
          $display("txn read  cont done=%b rdata=%h", done, rdata);
        end
        if (c == 19) req = '0;
      end
    end
  endtask

  task automatic test_drop_req;
    clear_inputs();
    set_req(0, 1'b0, 3'd1, '0);
    push_exp(4'b0001, 1'b1, init_val(1));
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if (gnt !== 4'b0001) begin
          n_err++; $display("FAIL drop_gnt: got %b, want 0001", gnt);
        end
        req = '0;
      end
      if (c == 3) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL drop_sb: got done=%b, want queued entry", done);
        end else begin
          e = exp_q.pop_front();
          n_cmp += 2;
          if (done !== e.done) begin
            n_err++; $display("FAIL drop_done: got %b, want %b", done, e.done);
          end
          if (rdata !== e.rdata) begin
            n_err++; $display("FAIL drop_rdata: got %h, want %h", rdata, e.rdata);
          end
          $display("txn read  drop done=%b rdata=%h", done, rdata);
        end
      end
      if (c >= 4) begin
        n_cmp++;
        if (gnt !== '0 || done !== '0) begin
          n_err++; $display("FAIL drop_regrant_t%0d: got gnt=%b done=%b, want 0/0", c, gnt, done);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write;
    clear_inputs();
    set_req(3, 1'b1, 3'd5, 18'h12345);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b1000 || reg_we !== 1'b0) begin
      n_err++; $display("FAIL rstw_setup: got gnt=%b we=%b, want 1000/0", gnt, reg_we);
    end
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    n_cmp++;
    if ({gnt, done, rdata, reg_addr, swap1, reg_we, reg_wdata} !== '0) begin
      n_err++;
      $display("FAIL rstw_outputs: got gnt=%b done=%b rdata=%h addr=%0d swap1=%b we=%b wdata=%h, want all 0",
               gnt, done, rdata, reg_addr, swap1, reg_we, reg_wdata);
    end
    rst = 1'b0;
    n_cmp++;
    if (bank[5] !== init_val(5)) begin
      n_err++; $display("FAIL rstw_bank: got %h, want %h", bank[5], init_val(5));
    end
    // ptr must be back at 0: with ptr=1 this pair would grant requester 3 first.
    clear_inputs();
    set_req(0, 1'b0, 3'd0, '0);
    set_req(3, 1'b0, 3'd3, '0);
    push_exp(4'b0001, 1'b1, 18'h3FFFF);
    push_exp(4'b1000, 1'b1, 18'h2A5A5);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1 || c == 5) begin
        n_cmp++;
        if (gnt !== ((c == 1) ? 4'b0001 : 4'b1000)) begin
          n_err++;
          $display("FAIL rstw_ptr_t%0d: got %b, want %b", c, gnt, (c == 1) ? 4'b0001 : 4'b1000);
        end
      end
      if (c == 3 || c == 7) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rstw_sb: got done=%b, want queued entry", done);
        end else begin
          e = exp_q.pop_front();
          n_cmp += 2;
          if (done !== e.done) begin
            n_err++; $display("FAIL rstw_done: got %b, want %b", done, e.done);
          end
          if (rdata !== e.rdata) begin
            n_err++; $display("FAIL rstw_rdata: got %h, want %h", rdata, e.rdata);
          end
          $display("txn read  post-rst done=%b rdata=%h", done, rdata);
        end
        if (c == 7) req = '0;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bank_load = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_wrap();
    test_contention();
    test_drop_req();
    test_reset_mid_write();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
